// File: rtl/cnn_downsampling_avg_01_if.sv
// Pixel stream bundle for the average-pool downsampler.
// The master drives the input stream and the slave (the pooler) drives the output stream.
interface cnn_downsampling_avg_01_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] pxl_in;
  logic [DATA_WIDTH-1:0] pxl_out;
  logic                  valid_out;
  logic                  frame_done;

  modport master (
    output valid_in, pxl_in,
    input  pxl_out, valid_out, frame_done
  );

  modport slave (
    input  valid_in, pxl_in,
    output pxl_out, valid_out, frame_done
  );
endinterface

// File: rtl/cnn_downsampling_avg_01.sv
// Streaming SCALE x SCALE average-pool downsampler over channel-major raster pixel streams.
// One accumulator per output column is reused for every block row.
module cnn_downsampling_avg_01 #(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 64,
  parameter int CHANNEL_NUM  = 256,
  parameter int SCALE        = 4
) (
  input logic                     clk,
  input logic                     reset,
  cnn_downsampling_avg_01_if.slave bus
);
  localparam int LOG2S     = $clog2(SCALE);
  localparam int SHIFT     = 2 * LOG2S;
  localparam int ACC_WIDTH = DATA_WIDTH + SHIFT;
  localparam int OUT_W     = IMAGE_WIDTH / SCALE;
  localparam int CW        = $clog2(IMAGE_WIDTH);
  localparam int RW        = $clog2(IMAGE_HEIGHT);
  localparam int HW        = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam int IW        = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [CW-1:0]    COL_MAX = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0]    ROW_MAX = RW'(IMAGE_HEIGHT - 1);
  localparam logic [HW-1:0]    CH_MAX  = HW'(CHANNEL_NUM - 1);
  localparam logic [LOG2S-1:0] SUB_MAX = '1;

  logic [CW-1:0]         cnt_col_q, cnt_col_d;
  logic [RW-1:0]         cnt_row_q, cnt_row_d;
  logic [HW-1:0]         cnt_channel_q, cnt_channel_d;
  logic [DATA_WIDTH-1:0] pxl_q, pxl_d;
  logic                  valid_q, valid_d;
  logic                  frame_done_q, frame_done_d;

  logic signed [ACC_WIDTH-1:0] acc_q [OUT_W];

  logic [IW-1:0]               idx;
  logic [LOG2S-1:0]            ro, co;
  logic                        col_last, row_last, ch_last;
  logic                        blk_start, blk_end;
  logic signed [ACC_WIDTH-1:0] pxl_ext, sum;

  assign idx       = IW'(cnt_col_q >> LOG2S);
  assign ro        = cnt_row_q[LOG2S-1:0];
  assign co        = cnt_col_q[LOG2S-1:0];
  assign col_last  = (cnt_col_q == COL_MAX);
  assign row_last  = (cnt_row_q == ROW_MAX);
  assign ch_last   = (cnt_channel_q == CH_MAX);
  assign blk_start = (ro == '0) && (co == '0);
  assign blk_end   = (ro == SUB_MAX) && (co == SUB_MAX);

  // Sign extension into SHIFT headroom bits: SCALE*SCALE addends can never overflow.
  assign pxl_ext = {{SHIFT{bus.pxl_in[DATA_WIDTH-1]}}, bus.pxl_in};
  assign sum     = acc_q[idx] + pxl_ext;

  // NOTE: every variable is given a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    cnt_col_d     = cnt_col_q;
    cnt_row_d     = cnt_row_q;
    cnt_channel_d = cnt_channel_q;
    pxl_d         = pxl_q;
    valid_d       = 1'b0;
    frame_done_d  = 1'b0;
    if (bus.valid_in) begin
      cnt_col_d = col_last ? '0 : cnt_col_q + 1'b1;
      if (col_last) begin
        cnt_row_d = row_last ? '0 : cnt_row_q + 1'b1;
        if (row_last) cnt_channel_d = ch_last ? '0 : cnt_channel_q + 1'b1;
      end
      if (blk_end) begin
        // Taking the bits above SHIFT is an arithmetic shift right: floor division.
        pxl_d        = sum[SHIFT +: DATA_WIDTH];
        valid_d      = 1'b1;
        frame_done_d = col_last && row_last && ch_last;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_col_q     <= '0;
      cnt_row_q     <= '0;
      cnt_channel_q <= '0;
      pxl_q         <= '0;
      valid_q       <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      cnt_col_q     <= cnt_col_d;
      cnt_row_q     <= cnt_row_d;
      cnt_channel_q <= cnt_channel_d;
      pxl_q         <= pxl_d;
      valid_q       <= valid_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // NOTE: the accumulator RAM has no reset; each block start overwrites its entry,
  // so stale contents are never read and the array can map onto plain memory.
  always_ff @(posedge clk) begin
    if (bus.valid_in && !blk_end) acc_q[idx] <= blk_start ? pxl_ext : sum;
  end

  assign bus.pxl_out    = pxl_q;
  assign bus.valid_out  = valid_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_cnn_downsampling_avg_01.sv
// Self-checking bench for the average-pool downsampler on an 8x8x2 frame with SCALE=4.
// Constant-fill vectors come from a table; other frames are checked against a block-average model.
module tb_cnn_downsampling_avg_01;
  localparam int DW   = 32;
  localparam int IW   = 8;
  localparam int IH   = 8;
  localparam int CH   = 2;
  localparam int S    = 4;
  localparam int NPIX = IW * IH * CH;
  localparam int NOUT = (IW / S) * (IH / S) * CH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cnn_downsampling_avg_01_if #(.DATA_WIDTH(DW)) bus ();

  cnn_downsampling_avg_01 #(
    .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .CHANNEL_NUM(CH), .SCALE(S)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [DW-1:0] v;
    bit            fd;
    int            idx;
  } out_t;

  typedef struct {
    string         name;
    logic [DW-1:0] fill;
    logic [DW-1:0] exp;
  } vec_t;

  out_t          mon_q[$];
  out_t          exp_q[$];
  logic [DW-1:0] frame_px[NPIX];
  int            in_count;
  int            stray_fd;
  int            n_checks;
  int            n_errors;

  // Outputs are sampled on the falling edge, half a cycle clear of the updating edge.
  always @(negedge clk) begin
    if (reset && bus.valid_out) mon_q.push_back('{bus.pxl_out, bus.frame_done, in_count - 1});
    if (reset && bus.frame_done && !bus.valid_out) stray_fd++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain mean of each SCALE x SCALE block, rounded toward -inf.
  task automatic build_expected();
    exp_q.delete();
    for (int c = 0; c < CH; c++)
      for (int br = 0; br < IH / S; br++)
        for (int bc = 0; bc < IW / S; bc++) begin
          longint s = 0;
          longint q;
          for (int r = 0; r < S; r++)
            for (int cc = 0; cc < S; cc++)
              s += longint'(signed'(frame_px[c*IW*IH + (br*S + r)*IW + bc*S + cc]));
          q = s / (S * S);
          if (s < 0 && (s % (S * S)) != 0) q = q - 1;
          exp_q.push_back('{q[DW-1:0], (c == CH-1) && (br == IH/S-1) && (bc == IW/S-1),
                            c*IW*IH + (br*S + S-1)*IW + bc*S + S-1});
        end
  endtask

  task automatic send(input logic [DW-1:0] v);
    bus.valid_in = 1'b1;
    bus.pxl_in   = v;
    @(posedge clk);
    in_count++;
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input int gap_max);
    mon_q.delete();
    in_count = 0;
    for (int i = 0; i < NPIX; i++) begin
      send(frame_px[i]);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
    idle(3);
  endtask

  task automatic compare_model(input string name, input bit check_idx);
    build_expected();
    check($sformatf("%s.count", name), mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      check($sformatf("%s[%0d].val", name, i), mon_q[i].v, exp_q[i].v);
      check($sformatf("%s[%0d].fd", name, i), mon_q[i].fd, exp_q[i].fd);
      if (check_idx) check($sformatf("%s[%0d].idx", name, i), mon_q[i].idx, exp_q[i].idx);
    end
  endtask

  task automatic check_list(input string name, input logic [DW-1:0] exp_v[NOUT]);
    check($sformatf("%s.count", name), mon_q.size(), NOUT);
    for (int i = 0; i < NOUT && i < mon_q.size(); i++)
      check($sformatf("%s[%0d].val", name, i), mon_q[i].v, exp_v[i]);
  endtask

  initial begin
    vec_t          vecs[5];
    int            blk_idx[NOUT];
    logic [DW-1:0] ramp_exp[NOUT];
    logic [DW-1:0] neg1_exp[NOUT];
    int            fd_cnt;

    vecs[0] = '{"const16", 32'd16,        32'd16};
    vecs[1] = '{"neg3",    32'hFFFF_FFFD, 32'hFFFF_FFFD};
    vecs[2] = '{"maxpos",  32'h7FFF_FFFF, 32'h7FFF_FFFF};
    vecs[3] = '{"minneg",  32'h8000_0000, 32'h8000_0000};
    vecs[4] = '{"zero",    32'd0,         32'd0};
    blk_idx  = '{27, 31, 59, 63, 91, 95, 123, 127};
    ramp_exp = '{32'd13, 32'd17, 32'd45, 32'd49, 32'd77, 32'd81, 32'd109, 32'd113};
    neg1_exp = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    n_checks = 0;
    n_errors = 0;
    stray_fd = 0;
    in_count = 0;

    reset        = 1'b0;
    bus.valid_in = 1'b0;
    bus.pxl_in   = '0;
    idle(3);
    check("reset.pxl_out", bus.pxl_out, 0);
    check("reset.valid_out", bus.valid_out, 0);
    check("reset.frame_done", bus.frame_done, 0);
    reset = 1'b1;
    idle(2);

    // Constant-fill frames: every block average equals the fill value.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NPIX; i++) frame_px[i] = vecs[k].fill;
      run_frame(0);
      check($sformatf("%s.count", vecs[k].name), mon_q.size(), NOUT);
      for (int i = 0; i < NOUT && i < mon_q.size(); i++) begin
        check($sformatf("%s[%0d].val", vecs[k].name, i), mon_q[i].v, vecs[k].exp);
        check($sformatf("%s[%0d].fd", vecs[k].name, i), mon_q[i].fd, i == NOUT - 1);
        check($sformatf("%s[%0d].idx", vecs[k].name, i), mon_q[i].idx, blk_idx[i]);
      end
    end

    // Ramp 0..127: x.5 averages must floor.
    for (int i = 0; i < NPIX; i++) frame_px[i] = DW'(i);
    run_frame(0);
    check_list("ramp", ramp_exp);
    compare_model("ramp_model", 1'b1);
    check("hold.pxl_out", bus.pxl_out, 113);
    check("hold.valid_out", bus.valid_out, 0);

    // Same ramp with idle gaps between pixels.
    run_frame(5);
    check_list("ramp_gap", ramp_exp);
    fd_cnt = 0;
    foreach (mon_q[i]) if (mon_q[i].fd) fd_cnt++;
    check("ramp_gap.fd_count", fd_cnt, 1);

    // One -1 among fifteen zeros floors to -1, not 0.
    for (int i = 0; i < NPIX; i++) frame_px[i] = '0;
    frame_px[9] = '1;
    run_frame(0);
    check_list("neg1", neg1_exp);

    // Random frames: full-range and small signed values, with random gaps.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NPIX; i++)
        frame_px[i] = (f < 2) ? DW'($urandom) : DW'($signed($urandom_range(0, 15)) - 8);
      run_frame(f % 2 == 0 ? 0 : 3);
      compare_model($sformatf("rand%0d", f), f % 2 == 0);
    end

    // Reset after 20 pixels: outputs clear, partial frame is discarded.
    mon_q.delete();
    in_count = 0;
    for (int i = 0; i < 20; i++) send(32'd1000);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("midrst%0d.pxl_out", c), bus.pxl_out, 0);
      check($sformatf("midrst%0d.valid_out", c), bus.valid_out, 0);
      check($sformatf("midrst%0d.frame_done", c), bus.frame_done, 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    idle(1);
    check("midrst.no_partial_out", mon_q.size(), 0);
    for (int i = 0; i < NPIX; i++) frame_px[i] = 32'd16;
    run_frame(0);
    compare_model("after_rst", 1'b1);

    check("stray_frame_done", stray_fd, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
